mem_access_seq: RTL and testbench

Sequencer for data-memory accesses in the single-issue core. It decodes load/store opcodes, drives a request/ready handshake to the data memory, and stalls the PC until the access completes. It gates the load register-file write to the completion cycle and aborts accesses that exceed a timeout. It sits between the instruction decode path and the data memory, and replaces the fixed two-cycle load stall with variable-latency sequencing.

---
 rtl/core_pkg.sv | 31 +++
 rtl/mem_access_seq_sat_counter.sv | 22 ++
 rtl/mem_access_seq.sv | 112 +++++++++++
 tb/tb_mem_access_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: opcode classes, sequencer state encoding and shared widths
// used by the data-memory access sequencer.
`default_nettype none

package core_pkg;

  localparam logic [4:0] OPC_LOAD    = 5'b00000;
  localparam logic [4:0] OPC_STORE   = 5'b01000;
  localparam int         STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } opc_class_t;

  function automatic opc_class_t opc_class(input logic [4:0] major);
    if (major == OPC_LOAD)       return CLS_LOAD;
    else if (major == OPC_STORE) return CLS_STORE;
    else                         return CLS_OTHER;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_seq_sat_counter.sv
// sat_counter: synchronous-reset up counter that holds at all-ones.
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_seq.sv
// mem_access_seq: load/store request/ready sequencer that stalls the PC
// until the data-memory access completes or times out.
`default_nettype none

module mem_access_seq
  import core_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [6:0]             i_opcode,
  input  logic                   i_memReady,
  output logic                   o_memReq,
  output logic                   o_memWrite,
  output logic                   o_PCEnable,
  output logic                   o_regWriteLoad,
  output logic                   o_busy,
  output logic                   o_fault,
  output logic [STALL_CNT_W-1:0] o_stallCount
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          r_isStore, is_store_next;
  logic          fault, fault_next;
  opc_class_t    cls;
  logic          unused_opc_bits;

  assign cls             = opc_class(i_opcode[6:2]);
  assign unused_opc_bits = ^i_opcode[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      r_isStore <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      r_isStore <= is_store_next;
      fault     <= fault_next;
    end
  end

  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    is_store_next  = r_isStore;
    fault_next     = fault;
    o_memReq       = 1'b0;
    o_memWrite     = 1'b0;
    o_PCEnable     = 1'b0;
    o_regWriteLoad = 1'b0;

    // Reset forces every handshake output low, including mid-access.
    if (!i_rst) begin
      case (state)
        IDLE: begin
          if (cls == CLS_OTHER) begin
            o_PCEnable     = 1'b1;
            o_regWriteLoad = 1'b1;
          end else begin
            o_memReq      = 1'b1;
            o_memWrite    = (cls == CLS_STORE);
            is_store_next = (cls == CLS_STORE);
            wait_cnt_next = '0;
            state_next    = WAIT;
          end
        end
        WAIT: begin
          o_memReq   = 1'b1;
          o_memWrite = r_isStore;
          if (i_memReady) begin
            o_PCEnable     = 1'b1;
            o_regWriteLoad = !r_isStore;
            state_next     = IDLE;
          end else begin
            wait_cnt_next = wait_cnt + CW'(1);
            if (wait_cnt == WAIT_LAST)
              state_next = ABORT;
          end
        end
        ABORT: begin
          o_PCEnable = 1'b1;
          fault_next = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign o_busy  = !i_rst && (state != IDLE);
  assign o_fault = fault;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (!o_PCEnable),
    .count (o_stallCount)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed self-checking bench for mem_access_seq (TIMEOUT=8).
`default_nettype none

module tb_mem_access_seq;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OTHER = 7'b0110011;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_write;
  logic        pc_en;
  logic        rwl;
  logic        busy;
  logic        fault;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  mem_access_seq #(
    .TIMEOUT (8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_opcode       (opcode),
    .i_memReady     (mem_ready),
    .o_memReq       (mem_req),
    .o_memWrite     (mem_write),
    .o_PCEnable     (pc_en),
    .o_regWriteLoad (rwl),
    .o_busy         (busy),
    .o_fault        (fault),
    .o_stallCount   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic req, input logic wr,
                      input logic pc, input logic rw, input logic bsy);
    check({tag, "/memReq"},       16'(mem_req),   16'(req));
    check({tag, "/memWrite"},     16'(mem_write), 16'(wr));
    check({tag, "/PCEnable"},     16'(pc_en),     16'(pc));
    check({tag, "/regWriteLoad"}, 16'(rwl),       16'(rw));
    check({tag, "/busy"},         16'(busy),      16'(bsy));
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = OP_LOAD;
    mem_ready = 1'b0;

    // Reset with a LOAD present: everything held low.
    tick(); settle();
    outs("rst0", 0, 0, 0, 0, 0);
    check("rst0/fault", 16'(fault), 16'h0);
    check("rst0/stall", stall_cnt, 16'd0);
    tick(); settle();
    outs("rst1", 0, 0, 0, 0, 0);

    // Release: request issued immediately, stall count still 0.
    rst = 1'b0; settle();
    outs("ld_req", 1, 0, 0, 0, 0);
    check("ld_req/stall", stall_cnt, 16'd0);

    // LOAD, ready on first WAIT cycle.
    tick(); mem_ready = 1'b1; settle();
    outs("ld_rdy", 1, 0, 1, 1, 1);
    tick(); mem_ready = 1'b0; opcode = OP_OTHER; settle();
    outs("ld_done", 0, 0, 1, 1, 0);
    check("ld_done/stall", stall_cnt, 16'd1);

    // STORE, ready 3 cycles after request: 3 stall cycles (total 4).
    opcode = OP_STORE; settle();
    outs("st_req", 1, 1, 0, 0, 0);
    tick(); settle();
    outs("st_w1", 1, 1, 0, 0, 1);
    tick(); settle();
    outs("st_w2", 1, 1, 0, 0, 1);
    tick(); mem_ready = 1'b1; settle();
    outs("st_rdy", 1, 1, 1, 0, 1);
    tick(); mem_ready = 1'b0; opcode = OP_OTHER; settle();
    outs("st_done", 0, 0, 1, 1, 0);
    check("st_done/stall", stall_cnt, 16'd4);

    // LOAD with ready in the request cycle (ignored) and again on 8th WAIT cycle.
    opcode = OP_LOAD; mem_ready = 1'b1; settle();
    outs("l8_req", 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick(); mem_ready = 1'b0; settle();
      outs("l8_wait", 1, 0, 0, 0, 1);
    end
    tick(); mem_ready = 1'b1; settle();
    outs("l8_rdy", 1, 0, 1, 1, 1);
    tick(); mem_ready = 1'b0; opcode = OP_OTHER; settle();
    outs("l8_done", 0, 0, 1, 1, 0);
    check("l8_done/fault", 16'(fault), 16'h0);
    check("l8_done/stall", stall_cnt, 16'd12);

    // LOAD timeout: 8 WAIT cycles, one ABORT cycle, sticky fault, 9 stalls (total 21).
    opcode = OP_LOAD; settle();
    outs("to_req", 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(); settle();
      outs("to_wait", 1, 0, 0, 0, 1);
    end
    tick(); settle();
    outs("to_abort", 0, 0, 1, 0, 1);
    check("to_abort/fault", 16'(fault), 16'h0);
    tick(); opcode = OP_OTHER; settle();
    outs("to_idle", 0, 0, 1, 1, 0);
    check("to_idle/fault", 16'(fault), 16'h1);
    check("to_idle/stall", stall_cnt, 16'd21);
    tick(); tick(); settle();
    check("to_sticky/fault", 16'(fault), 16'h1);
    check("to_sticky/stall", stall_cnt, 16'd21);

    // Reset raised on the 2nd WAIT cycle abandons the access.
    opcode = OP_LOAD; settle();
    outs("rm_req", 1, 0, 0, 0, 0);
    tick(); settle();
    outs("rm_w1", 1, 0, 0, 0, 1);
    tick(); rst = 1'b1; settle();
    outs("rm_rst", 0, 0, 0, 0, 0);
    tick(); settle();
    check("rm_after/fault", 16'(fault), 16'h0);
    check("rm_after/stall", stall_cnt, 16'd0);
    rst = 1'b0; opcode = OP_OTHER; settle();
    outs("rm_other", 0, 0, 1, 1, 0);
    tick(); settle();
    outs("rm_other2", 0, 0, 1, 1, 0);
    check("rm_other2/fault", 16'(fault), 16'h0);
    check("rm_other2/stall", stall_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
